// File: rtl/qammod_stream.sv
// Streaming QAM mapper: packs IN_W-bit words into k-bit symbols (k = 2/4/6/8 by mode) and
// Gray-maps each half to signed I/Q amplitudes, with valid/ready on both sides and flush/last.
module qammod_stream #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned KMAX  = 8,
  parameter int unsigned AMP_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [IN_W-1:0]         s,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    flush,
  output logic signed [AMP_W-1:0] i,
  output logic signed [AMP_W-1:0] q,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic                    o_last
);

  localparam int unsigned BUF_W  = IN_W + KMAX;
  localparam int unsigned FILL_W = $clog2(BUF_W + 1);
  localparam int unsigned HMAX   = KMAX / 2;

  logic [BUF_W-1:0]        acc_q, acc_d, acc_shift;
  logic [FILL_W-1:0]       fill_q, fill_d, fill_mid;
  logic [1:0]              mode_q, mode_d;
  logic                    pend_q, pend_d;
  logic                    en_q;
  logic signed [AMP_W-1:0] i_q, i_d, q_q, q_d;
  logic                    ov_q, ov_d, last_q, last_d;

  logic [FILL_W-1:0] k, h, sh_i, sh_q;
  logic [KMAX-1:0]   top, mask_h;
  logic [HMAX-1:0]   g_i, g_q;
  logic              wr, rd, pad, slot, flush_take, is_last;

  // Gray code to offset-binary amplitude: 2*b - (2^h - 1)
  function automatic logic signed [AMP_W-1:0] map_axis(input logic [HMAX-1:0] g,
                                                       input logic [FILL_W-1:0] hw);
    logic [HMAX-1:0]  b;
    logic [AMP_W-1:0] two_b, lm1;
    b = g;
    for (int n = 1; n < int'(HMAX); n++) b = b ^ (g >> n);
    two_b = AMP_W'({b, 1'b0});
    lm1   = (AMP_W'(1) << hw) - AMP_W'(1);
    return signed'(two_b - lm1);
  endfunction

  assign h       = FILL_W'(mode_q) + FILL_W'(1);
  assign k       = {h[FILL_W-2:0], 1'b0};
  assign s_ready = en_q && !pend_q && (fill_q <= FILL_W'(BUF_W - IN_W));

  always_comb begin
    wr         = s_valid && s_ready;
    slot       = !ov_q || o_ready;
    pad        = pend_q && (fill_q != '0) && (fill_q < k);
    rd         = slot && ((fill_q >= k) || pad);
    flush_take = flush && !pend_q && ((fill_q != '0) || wr);

    fill_mid  = rd ? (pad ? '0 : fill_q - k) : fill_q;
    fill_d    = fill_mid + (wr ? FILL_W'(IN_W) : '0);
    acc_shift = rd ? (acc_q << k) : acc_q;
    // Bits below fill are always zero, so a padded read sees zero LSBs for free.
    acc_d     = acc_shift | (wr ? ({s, {KMAX{1'b0}}} >> fill_mid) : '0);
    is_last   = (pend_q || flush_take) && rd && (fill_d == '0);

    top    = acc_q[BUF_W-1 -: KMAX];
    sh_i   = FILL_W'(KMAX) - h;
    sh_q   = FILL_W'(KMAX) - k;
    mask_h = (KMAX'(1) << h) - KMAX'(1);
    g_i    = HMAX'(top >> sh_i);
    g_q    = HMAX'((top >> sh_q) & mask_h);

    mode_d = ((fill_q == '0) && !wr && !rd) ? mode : mode_q;

    pend_d = pend_q;
    if (ov_q && o_ready && last_q) pend_d = 1'b0;
    if (flush_take) pend_d = 1'b1;

    i_d    = i_q;
    q_d    = q_q;
    ov_d   = ov_q;
    last_d = last_q;
    if (rd) begin
      i_d    = map_axis(g_i, h);
      q_d    = map_axis(g_q, h);
      ov_d   = 1'b1;
      last_d = is_last;
    end else if (o_ready) begin
      ov_d   = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      fill_q <= '0;
      mode_q <= '0;
      pend_q <= 1'b0;
      en_q   <= 1'b0;
      i_q    <= '0;
      q_q    <= '0;
      ov_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      en_q   <= 1'b1;
      i_q    <= i_d;
      q_q    <= q_d;
      ov_q   <= ov_d;
      last_q <= last_d;
    end
  end

  assign i       = i_q;
  assign q       = q_q;
  assign o_valid = ov_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_qammod_stream.sv
// Bench for qammod_stream: bit-queue reference model with a per-cycle scoreboard,
// directed scenarios with literal expectations, then randomized bursts.
module tb_qammod_stream;
  localparam int IN_W = 8;
  localparam int KMAX = 8;
  localparam int AMP_W = 5;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [1:0]              mode = 2'd0;
  logic [IN_W-1:0]         s = '0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic                    flush = 1'b0;
  logic signed [AMP_W-1:0] i, q;
  logic                    o_valid;
  logic                    o_ready = 1'b0;
  logic                    o_last;

  always #5 clk = ~clk;

  qammod_stream #(.IN_W(IN_W), .KMAX(KMAX), .AMP_W(AMP_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .s(s), .s_valid(s_valid), .s_ready(s_ready),
    .flush(flush), .i(i), .q(q), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last)
  );

  typedef struct {int i; int q; bit last; int cyc;} sym_t;

  sym_t exp_q[$];
  sym_t got_q[$];
  bit   bq[$];
  int   m_mode = 0;
  bit   m_pend = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   prev_stall = 0;
  int   p_i, p_q;
  bit   p_last;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference mapping straight from the rule: b = gray2bin(g), amplitude = 2b - (2^h - 1).
  function automatic int amp(input int g, input int h);
    int b = 0;
    for (int n = 0; n < h; n++) b = b ^ (g >> n);
    return 2 * b - ((1 << h) - 1);
  endfunction

  function automatic void form_sym();
    sym_t t;
    int h = m_mode + 1;
    int gi = 0;
    int gq = 0;
    for (int n = 0; n < h; n++) gi = gi * 2 + int'(bq.pop_front());
    for (int n = 0; n < h; n++) gq = gq * 2 + int'(bq.pop_front());
    t.i = amp(gi, h); t.q = amp(gq, h); t.last = 0; t.cyc = 0;
    exp_q.push_back(t);
  endfunction

  // Monitor: at the negedge, inputs and outputs show what the next posedge will capture.
  always @(negedge clk) begin
    sym_t e, t;
    bit   wr;
    cyc++;
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(o_valid), 1);
        chk("hold_i", int'(i), p_i);
        chk("hold_q", int'(q), p_q);
        chk("hold_last", int'(o_last), int'(p_last));
      end
      if (m_pend) chk("ready_blocked_by_flush", int'(s_ready), 0);
      wr = s_valid && s_ready;
      if (wr) begin
        for (int n = IN_W - 1; n >= 0; n--) bq.push_back(s[n]);
        while (bq.size() >= 2 * (m_mode + 1)) form_sym();
      end
      if (flush && !m_pend && (wr || bq.size() > 0)) begin
        if (bq.size() > 0) begin
          while (bq.size() < 2 * (m_mode + 1)) bq.push_back(1'b0);
          form_sym();
        end
        t = exp_q.pop_back();
        t.last = 1;
        exp_q.push_back(t);
        m_pend = 1;
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_symbol", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sym_i", int'(i), e.i);
          chk("sym_q", int'(q), e.q);
          chk("sym_last", int'(o_last), int'(e.last));
          if (e.last) m_pend = 0;
        end
        t.i = int'(i); t.q = int'(q); t.last = o_last; t.cyc = cyc;
        got_q.push_back(t);
      end
      prev_stall = o_valid && !o_ready;
      p_i = int'(i); p_q = int'(q); p_last = o_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [7:0] d);
    int n = 0;
    s = d;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("put_word_timeout", 1, 0);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    o_ready = 1'b1;
    while ((exp_q.size() > 0 || m_pend) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 1, 0);
    tick();
  endtask

  task automatic set_mode(input int m);
    mode = 2'(m);
    s_valid = 1'b0;
    repeat (3) tick();
    m_mode = m;
    got_q.delete();
  endtask

  task automatic chk_sym(input string name, input int idx, input int ei, input int eq,
                         input bit el);
    if (idx >= got_q.size()) begin
      chk({name, "_missing"}, got_q.size(), idx + 1);
    end else begin
      chk({name, "_i"}, got_q[idx].i, ei);
      chk({name, "_q"}, got_q[idx].q, eq);
      chk({name, "_last"}, int'(got_q[idx].last), int'(el));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    #3 rst = 1'b0;
    #1;
    chk("rst_i", int'(i), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_last", int'(o_last), 0);
    chk("rst_ready", int'(s_ready), 0);
    // Pin the reference mapping to hand-computed points.
    chk("model_qpsk0", amp(0, 1), -1);
    chk("model_qpsk1", amp(1, 1), 1);
    chk("model_16q_11", amp(3, 2), 1);
    chk("model_16q_10", amp(2, 2), 3);
    chk("model_256_1000", amp(8, 4), 15);
    @(posedge clk);
    #3 rst = 1'b1;
    chk("ready_before_edge", int'(s_ready), 0);
    tick();
    chk("ready_after_edge", int'(s_ready), 1);

    // 16-QAM single word
    set_mode(1);
    o_ready = 1'b1;
    put_word(8'b0001_1110);
    drain();
    chk("t1_count", got_q.size(), 2);
    chk_sym("t1_s0", 0, -3, -1, 0);
    chk_sym("t1_s1", 1, 1, 3, 0);

    // QPSK
    set_mode(0);
    put_word(8'hA5);
    drain();
    chk("t2_count", got_q.size(), 4);
    chk_sym("t2_s0", 0, 1, -1, 0);
    chk_sym("t2_s2", 2, -1, 1, 0);
    chk_sym("t2_s3", 3, -1, 1, 0);

    // 256-QAM back-to-back, one symbol per clock
    set_mode(3);
    s_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      s = (w == 0) ? 8'h00 : (w == 1) ? 8'h80 : 8'hFF;
      @(negedge clk);
      chk("t3_ready", int'(s_ready), 1);
      tick();
    end
    s_valid = 1'b0;
    drain();
    chk("t3_count", got_q.size(), 3);
    chk_sym("t3_s0", 0, -15, -15, 0);
    chk_sym("t3_s1", 1, 15, -15, 0);
    chk_sym("t3_s2", 2, 5, 5, 0);
    if (got_q.size() == 3) begin
      chk("t3_gap01", got_q[1].cyc - got_q[0].cyc, 1);
      chk("t3_gap12", got_q[2].cyc - got_q[1].cyc, 1);
    end

    // 64-QAM with flush and padding
    set_mode(2);
    put_word(8'hFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain();
    chk_sym("t4_s0", 0, 3, 3, 0);
    chk_sym("t4_s1", 1, 1, -7, 1);
    chk("t4_ready_after", int'(s_ready), 1);

    // QPSK stall
    set_mode(0);
    o_ready = 1'b0;
    put_word(8'h3C);
    put_word(8'hC3);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("t5_ready_low", int'(s_ready), 0);
      chk("t5_valid_high", int'(o_valid), 1);
      tick();
    end
    drain();
    chk("t5_count", got_q.size(), 8);
    chk_sym("t5_s0", 0, -1, -1, 0);
    chk_sym("t5_s3", 3, -1, -1, 0);
    chk_sym("t5_s4", 4, 1, 1, 0);

    // Mode change mid-burst is deferred until empty
    set_mode(0);
    o_ready = 1'b1;
    put_word(8'h5A);
    mode = 2'd3;
    put_word(8'hF0);
    drain();
    chk("t6_count", got_q.size(), 8);
    chk_sym("t6_s0", 0, -1, 1, 0);
    chk_sym("t6_s4", 4, 1, 1, 0);
    chk_sym("t6_s7", 7, -1, -1, 0);
    repeat (3) tick();
    m_mode = 3;
    got_q.delete();
    put_word(8'h80);
    drain();
    chk_sym("t6_256", 0, 15, -15, 0);

    // Reset mid-burst
    set_mode(0);
    o_ready = 1'b0;
    put_word(8'hFF);
    tick();
    tick();
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_valid", int'(o_valid), 0);
    chk("t6_rst_i", int'(i), 0);
    chk("t6_rst_q", int'(q), 0);
    chk("t6_rst_last", int'(o_last), 0);
    chk("t6_rst_ready", int'(s_ready), 0);
    bq.delete();
    exp_q.delete();
    m_pend = 0;
    m_mode = 0;
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    chk("t6_ready_again", int'(s_ready), 1);
    got_q.delete();
    o_ready = 1'b1;
    put_word(8'hC0);
    drain();
    chk("t6_post_count", got_q.size(), 4);
    chk_sym("t6_post_s0", 0, 1, 1, 0);
    chk_sym("t6_post_s1", 1, -1, -1, 0);

    // Randomized bursts against the model
    for (int b = 0; b < 8; b++) begin
      set_mode((b < 4) ? b : int'($urandom_range(3, 0)));
      for (int c = 0; c < 250; c++) begin
        s_valid = ($urandom_range(3, 0) != 0);
        s = IN_W'($urandom);
        o_ready = ($urandom_range(3, 0) != 0);
        flush = ($urandom_range(9, 0) == 0) &&
                ((s_valid && s_ready) || bq.size() > 0 || m_pend);
        tick();
      end
      s_valid = 1'b0;
      flush = 1'b0;
      o_ready = 1'b1;
      if (!m_pend && bq.size() > 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      drain();
      chk("rand_model_empty", exp_q.size() + bq.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
